// File: rtl/c3lib_ckmux4_sel_ctrl_pkg.sv
// c3lib_ckmux4_sel_ctrl_pkg: shared types and default parameter values for the clock-mux select sequencer
package c3lib_ckmux4_sel_ctrl_pkg;
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GATE   = 3'd1,
    ST_SWITCH = 3'd2,
    ST_SETTLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;
  typedef logic [1:0] sel_t;
  localparam int   DEF_GATE_CYC   = 4;
  localparam int   DEF_SETTLE_CYC = 8;
  localparam int   DEF_CNT_W      = 4;
  localparam sel_t DEF_RST_SEL    = 2'b00;
endpackage

// File: rtl/c3lib_ckmux4_sel_ctrl_cnt.sv
// c3lib_ckmux4_sel_ctrl_cnt: loadable down-counter that flags when it reads 1 and never decrements past 0
//   clk, rst    : clock and synchronous active-high reset (reset loads RST_VAL)
//   i_load      : load i_load_val on the next edge (wins over decrement)
//   i_load_val  : value to load
//   i_dec       : decrement request, ignored while the count is 0
//   o_last      : count equals 1
module c3lib_ckmux4_sel_ctrl_cnt #(
  parameter int               CNT_W   = 4,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_last
);
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge clk) begin
    r_cnt <= rst ? RST_VAL :
             i_load ? i_load_val :
             (i_dec && r_cnt != '0) ? r_cnt - 1'b1 : r_cnt;
  end
  assign o_last = r_cnt == CNT_W'(1);
endmodule

// File: rtl/c3lib_ckmux4_sel_ctrl.sv
// c3lib_ckmux4_sel_ctrl: runt-free select sequencer for a 4:1 clock mux and its downstream clock gate
//   clk, rst        : reference clock, synchronous active-high reset
//   sel_vld/sel_val : select-change request and requested {s1,s0}
//   sel_rdy         : request can be accepted (IDLE and not in test override)
//   sel_done        : one-cycle pulse when a requested switch completes
//   busy            : sequencer not in IDLE
//   tst_override    : blocks new requests only
//   err_clr/sel_err : sticky protocol-error flag and its clear, active with C3LIB_CKMUX_SEL_ERR_EN
//   s0, s1, cur_sel : registered mux select
//   ck_en           : registered clock-gate enable
module c3lib_ckmux4_sel_ctrl
  import c3lib_ckmux4_sel_ctrl_pkg::*;
#(
  parameter int   GATE_CYC   = DEF_GATE_CYC,
  parameter int   SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int   CNT_W      = DEF_CNT_W,
  parameter sel_t RST_SEL    = DEF_RST_SEL
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sel_vld,
  input  logic [1:0] sel_val,
  output logic       sel_rdy,
  output logic       sel_done,
  output logic       busy,
  input  logic       tst_override,
  input  logic       err_clr,
  output logic       sel_err,
  output logic       s0,
  output logic       s1,
  output logic       ck_en,
  output logic [1:0] cur_sel
);
  if (GATE_CYC < 1 || GATE_CYC >= (1 << CNT_W)) begin : g_gate_chk
    $error("GATE_CYC must be in 1..2**CNT_W-1");
  end
  if (SETTLE_CYC < 1 || SETTLE_CYC >= (1 << CNT_W)) begin : g_settle_chk
    $error("SETTLE_CYC must be in 1..2**CNT_W-1");
  end
  state_t           r_state;
  sel_t             r_sel;
  sel_t             r_new;
  logic             r_ck_en;
  logic             r_done;
  logic             r_init;
  logic             w_xfer;
  logic             w_same;
  logic             w_load;
  logic             w_dec;
  logic             w_last;
  logic [CNT_W-1:0] w_load_val;
  assign sel_rdy    = (r_state == ST_IDLE) & ~tst_override;
  assign w_xfer     = sel_vld & sel_rdy;
  assign w_same     = sel_val == r_sel;
  // GATE is loaded on a real switch request, SETTLE on the way out of SWITCH
  assign w_load     = (w_xfer & ~w_same) | (r_state == ST_SWITCH);
  assign w_load_val = (r_state == ST_SWITCH) ? CNT_W'(SETTLE_CYC) : CNT_W'(GATE_CYC);
  assign w_dec      = (r_state == ST_GATE) | (r_state == ST_SETTLE);
  c3lib_ckmux4_sel_ctrl_cnt #(
    .CNT_W   (CNT_W),
    .RST_VAL (CNT_W'(SETTLE_CYC))
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_last     (w_last)
  );
  // Reset enters SETTLE so the gate opens only after the reset select has settled;
  // r_init hides the completion pulse of that start-up pass.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_SETTLE;
      r_sel   <= RST_SEL;
      r_new   <= RST_SEL;
      r_ck_en <= 1'b0;
      r_done  <= 1'b0;
      r_init  <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_xfer) begin
            r_state <= w_same ? ST_DONE : ST_GATE;
            r_ck_en <= w_same;
            r_done  <= w_same;
            r_new   <= sel_val;
          end
        end
        ST_GATE: begin
          if (w_last) begin
            r_state <= ST_SWITCH;
            r_sel   <= r_new;
          end
        end
        ST_SWITCH: r_state <= ST_SETTLE;
        ST_SETTLE: begin
          if (w_last) begin
            r_state <= ST_DONE;
            r_ck_en <= 1'b1;
            r_done  <= ~r_init;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_init  <= 1'b0;
        end
        default: begin
          r_state <= ST_SETTLE;
          r_ck_en <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end
  assign busy     = r_state != ST_IDLE;
  assign sel_done = r_done;
  assign ck_en    = r_ck_en;
  assign s0       = r_sel[0];
  assign s1       = r_sel[1];
  assign cur_sel  = r_sel;
`ifdef C3LIB_CKMUX_SEL_ERR_EN
  logic r_err;
  always_ff @(posedge clk) begin
    r_err <= rst ? 1'b0 : (sel_vld & ~sel_rdy) ? 1'b1 : err_clr ? 1'b0 : r_err;
  end
  assign sel_err = r_err;
`else
  logic w_unused;
  assign w_unused = err_clr;
  assign sel_err  = 1'b0;
`endif
endmodule

// File: tb/tb_c3lib_ckmux4_sel_ctrl.sv
// tb_c3lib_ckmux4_sel_ctrl: directed plus random stimulus against a cycle-schedule reference model
module tb_c3lib_ckmux4_sel_ctrl;
  localparam int         G       = 4;
  localparam int         S       = 8;
  localparam logic [1:0] RST_SEL = 2'b10;
  localparam int         INF     = 1 << 30;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel_vld = 1'b0;
  logic [1:0] sel_val = 2'b00;
  logic       tst_override = 1'b0;
  logic       err_clr = 1'b0;
  logic       sel_rdy, sel_done, busy, sel_err, s0, s1, ck_en;
  logic [1:0] cur_sel;
  c3lib_ckmux4_sel_ctrl #(
    .GATE_CYC   (G),
    .SETTLE_CYC (S),
    .CNT_W      (4),
    .RST_SEL    (RST_SEL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sel_vld      (sel_vld),
    .sel_val      (sel_val),
    .sel_rdy      (sel_rdy),
    .sel_done     (sel_done),
    .busy         (busy),
    .tst_override (tst_override),
    .err_clr      (err_clr),
    .sel_err      (sel_err),
    .s0           (s0),
    .s1           (s1),
    .ck_en        (ck_en),
    .cur_sel      (cur_sel)
  );
  always #5 clk = ~clk;
  int         n_chk = 0;
  int         n_err = 0;
  int         cyc = 0;
  bit         armed = 0;
  // Reference model: each accepted event is turned into absolute cycle numbers
  logic [1:0] old_sel = RST_SEL;
  logic [1:0] new_sel = RST_SEL;
  int         sw_at = INF;
  int         ckoff_from = 0;
  int         done_at = 0;
  bit         pulse = 0;
  int         idle_at = INF;
  bit         m_err = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc %0d got %0h exp %0h", tag, cyc, got, exp);
    end
  endtask
  function automatic logic [1:0] exp_sel(input int n);
    return n >= sw_at ? new_sel : old_sel;
  endfunction
  task automatic step(input bit r, input bit v, input logic [1:0] val, input bit t, input bit c);
    bit         e_busy, e_rdy, e_err;
    logic [1:0] cur;
    @(posedge clk);
    cyc++;
    #1;
    rst = r; sel_vld = v; sel_val = val; tst_override = t; err_clr = c;
    @(negedge clk);
    e_busy = cyc < idle_at;
    e_rdy  = !e_busy && !t;
`ifdef C3LIB_CKMUX_SEL_ERR_EN
    e_err = m_err;
`else
    e_err = 1'b0;
`endif
    if (armed) begin
      chk("busy", 32'(busy), 32'(e_busy));
      chk("sel_rdy", 32'(sel_rdy), 32'(e_rdy));
      chk("sel_done", 32'(sel_done), 32'(cyc == done_at && pulse));
      chk("ck_en", 32'(ck_en), 32'(!(cyc >= ckoff_from && cyc < done_at)));
      chk("s1s0", 32'({s1, s0}), 32'(exp_sel(cyc)));
      chk("cur_sel", 32'(cur_sel), 32'(exp_sel(cyc)));
      chk("sel_err", 32'(sel_err), 32'(e_err));
    end
    if (r) begin
      old_sel = RST_SEL; new_sel = RST_SEL; sw_at = INF;
      ckoff_from = cyc + 1; done_at = cyc + 1 + S; pulse = 0; idle_at = cyc + 2 + S;
      m_err = 0; armed = 1;
    end else begin
      if (v && !e_rdy) m_err = 1;
      else if (c) m_err = 0;
      if (v && e_rdy) begin
        cur = exp_sel(cyc);
        old_sel = cur; pulse = 1; ckoff_from = cyc + 1;
        if (val == cur) begin
          new_sel = cur; sw_at = INF; done_at = cyc + 1; idle_at = cyc + 2;
        end else begin
          new_sel = val; sw_at = cyc + G + 1; done_at = cyc + G + S + 2; idle_at = cyc + G + S + 3;
        end
      end
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 2'b00, 0, 0);
  endtask
  initial begin
    bit tst = 0;
    repeat (3) step(1, 0, 2'b00, 0, 0);
    idle(12);
    step(0, 1, 2'b01, 0, 0);
    idle(2);
    step(0, 1, 2'b11, 0, 0);
    idle(14);
    step(0, 0, 2'b00, 0, 1);
    idle(2);
    step(0, 1, 2'b01, 0, 0);
    idle(3);
    step(0, 1, 2'b10, 0, 0);
    idle(3);
    for (int i = 0; i < 16; i++) step(0, 1, 2'b00, 1, 0);
    idle(3);
    step(0, 1, 2'b11, 0, 0);
    idle(6);
    step(1, 0, 2'b00, 0, 0);
    idle(12);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) tst = ~tst;
      step($urandom_range(0, 499) == 0, $urandom_range(0, 2) == 0,
           2'($urandom_range(0, 3)), tst, $urandom_range(0, 7) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/c3lib_ckmux4_sel_ctrl.md
Name: c3lib_ckmux4_sel_ctrl

Overview:
- Sequencer that owns the select lines of a 4-to-1 clock mux and the enable of a downstream clock gate.
- On each select-change request it closes the gate, waits for drain, switches the select, waits for settle, then reopens the gate and reports completion.
- Sits next to the clock mux, clocked by an always-running reference clock.
- Prevents runt pulses when software or training logic retargets the clock source.

Parameters:
- GATE_CYC, 4, cycles held in GATE state (ck_en low before select changes); legal range 1..2**CNT_W-1.
- SETTLE_CYC, 8, cycles held in SETTLE state (after select changes, before ck_en rises); legal range 1..2**CNT_W-1.
- CNT_W, 4, width of the internal down-counter.
- RST_SEL, 2'b00, select value driven from reset.

Ports:
- clk  input  1  free-running reference clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- sel_vld  input  1  request valid; new select presented on sel_val.
- sel_val  input  2  requested select {s1,s0}.
- sel_rdy  output  1  controller can accept a request.
- sel_done  output  1  one-cycle pulse when a requested switch completes.
- busy  output  1  high in any state other than IDLE.
- tst_override  input  1  test mode; blocks new requests.
- err_clr  input  1  clears sel_err (optional feature).
- sel_err  output  1  sticky protocol-error flag (optional feature).
- s0  output  1  mux select bit 0, registered.
- s1  output  1  mux select bit 1, registered.
- ck_en  output  1  downstream clock-gate enable, registered.
- cur_sel  output  2  currently applied select; equals {s1,s0}.

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset values:
  - {s1,s0} = RST_SEL; ck_en = 0; sel_done = 0; sel_rdy = 0; busy = 1; sel_err = 0.
  - State = SETTLE, counter = SETTLE_CYC, init flag set.
- States: IDLE, GATE, SWITCH, SETTLE, DONE.
- Handshake:
  - sel_rdy = (state == IDLE) & ~tst_override.
  - A transfer occurs on a cycle with sel_vld & sel_rdy.
  - sel_val is sampled only in the transfer cycle.
- Same-select request (sel_val == cur_sel): IDLE -> DONE.
  - sel_done pulses at T+1; ck_en stays high; no gating.
- Different-select request, accepted at cycle T:
  - T+1..T+GATE_CYC: GATE, ck_en = 0.
  - T+GATE_CYC+1: SWITCH, one cycle; {s1,s0} show the new value in this cycle.
  - Next SETTLE_CYC cycles: SETTLE, ck_en = 0.
  - T+GATE_CYC+SETTLE_CYC+2: DONE; ck_en = 1 and sel_done = 1 in this same cycle.
  - Next cycle: IDLE, sel_rdy = 1 (if tst_override = 0).
  - ck_en is low for exactly GATE_CYC+1+SETTLE_CYC cycles.
- s0/s1 change only on entry to SWITCH (or on reset). They never change while ck_en = 1.
- Counter:
  - Loaded on entry to GATE or SETTLE; decremented each cycle.
  - State exits when the counter reads 1. No wrap; the counter is never decremented at 0.
- Post-reset initialisation: SETTLE -> DONE with ck_en = 1 but sel_done suppressed (init flag), then IDLE. The init flag clears on leaving DONE.
- Requests while busy are not accepted, not queued, and have no effect on sequencing.
- tst_override:
  - Only gates sel_rdy.
  - A sequence already in progress completes normally.
  - Asserting it in the same cycle as sel_vld blocks the transfer.
- Reset mid-sequence: immediate return to reset values (select forced to RST_SEL, ck_en = 0), then the initialisation sequence runs.
- Parameter check: an elaboration-time error fires if GATE_CYC or SETTLE_CYC is 0 or does not fit in CNT_W.

Optional Feature:
- Macro: C3LIB_CKMUX_SEL_ERR_EN.
- Defined:
  - sel_err sets (sticky) on any cycle with sel_vld = 1 and sel_rdy = 0.
  - err_clr = 1 clears it in the next cycle.
  - Set wins over clear in the same cycle.
  - Reset clears it.
- Undefined: sel_err is tied 0 and err_clr is ignored. Ports remain present.

Decomposition:
- Package c3lib_ckmux4_sel_ctrl_pkg:
  - state enum (IDLE, GATE, SWITCH, SETTLE, DONE) as logic[2:0].
  - sel typedef logic[1:0].
  - Default-value localparams.
- Sub-module c3lib_ckmux4_sel_ctrl_cnt:
  - Loadable CNT_W down-counter.
  - Inputs: load, load value, decrement. Output: last (counter == 1).

Test Plan:
- Reset, GATE_CYC=4, SETTLE_CYC=8, RST_SEL=2'b10 -> {s1,s0}=10 and ck_en=0 for 8 cycles after reset release, then ck_en=1, no sel_done, sel_rdy=1 the following cycle.
- Request sel_val=2'b01 at T -> ck_en=0 at T+1..T+13, s=01 first at T+5, ck_en=1 with sel_done=1 at T+14, sel_rdy=1 at T+15.
- Request sel_val equal to cur_sel -> sel_done at T+1, ck_en never drops, s unchanged.
- sel_vld pulsed at T+3 with sel_val=2'b11 during a sequence -> ignored, final s is the first request's value; with C3LIB_CKMUX_SEL_ERR_EN, sel_err=1 at T+4 and stays 1 until err_clr.
- tst_override=1 mid-sequence -> sequence completes at the same cycle count, sel_rdy stays 0 until tst_override=0.
- rst asserted at T+7 during SETTLE -> next cycle s=RST_SEL and ck_en=0; initialisation sequence repeats with no sel_done.
